// File: rtl/rectangle_filled_generator.sv
// Filled-rectangle point streamer: emits (a+col, b+row, row, col) row-major.
// Option: RECTANGLE_FILLED_ZERO_IDLE_EN forces outputs to 0 while _valid=0.
module rectangle_filled_generator #(
  parameter int WIDTH = 32
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] _out0,
  output logic [WIDTH-1:0] _out1,
  output logic [WIDTH-1:0] _out2,
  output logic [WIDTH-1:0] _out3,
  output logic             _valid,
  output logic             _done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic signed [WIDTH-1:0] ZERO = '0;
  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t state_q;
  state_t state_d;

  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic signed [WIDTH-1:0] c_q;
  logic signed [WIDTH-1:0] d_q;
  logic signed [WIDTH-1:0] row_q;
  logic signed [WIDTH-1:0] col_q;

  logic [WIDTH-1:0] out0_d;
  logic [WIDTH-1:0] out1_d;
  logic [WIDTH-1:0] out2_d;
  logic [WIDTH-1:0] out3_d;
  logic             valid_d;
  logic             done_d;

  logic start_ok;
  logic col_wrap;
  logic last_pt;

  // Empty rectangles never leave IDLE.
  assign start_ok = _start
                 && ($signed(c) > ZERO)
                 && ($signed(d) > ZERO);
  assign col_wrap = (col_q == d_q - ONE);
  assign last_pt  = col_wrap
                 && (row_q == c_q - ONE);

  // State register.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave RUN right after the final point.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_pt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and row/col scan counters.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (state_q == IDLE) begin
      if (_start) begin
        a_q   <= a;
        b_q   <= b;
        c_q   <= c;
        d_q   <= d;
        row_q <= '0;
        col_q <= '0;
      end
    end else begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= row_q + ONE;
      end else begin
        col_q <= col_q + ONE;
      end
    end
  end

  // Output decode: a point per RUN cycle, done one edge after RUN ends.
  always_comb begin
    out0_d  = _out0;
    out1_d  = _out1;
    out2_d  = _out2;
    out3_d  = _out3;
    valid_d = 1'b0;
    done_d  = (state_q == IDLE)
           && (state_d == IDLE);
    if (state_q == RUN) begin
      out0_d  = a_q + col_q;
      out1_d  = b_q + row_q;
      out2_d  = row_q;
      out3_d  = col_q;
      valid_d = 1'b1;
    end
`ifdef RECTANGLE_FILLED_ZERO_IDLE_EN
    else begin
      out0_d = '0;
      out1_d = '0;
      out2_d = '0;
      out3_d = '0;
    end
`endif
  end

  // Registered outputs.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      _out0  <= '0;
      _out1  <= '0;
      _out2  <= '0;
      _out3  <= '0;
      _valid <= 1'b0;
      _done  <= 1'b1;
    end else begin
      _out0  <= out0_d;
      _out1  <= out1_d;
      _out2  <= out2_d;
      _out3  <= out3_d;
      _valid <= valid_d;
      _done  <= done_d;
    end
  end

endmodule

// File: tb/tb_rectangle_filled_generator.sv
// Bench for rectangle_filled_generator: vector table plus scoreboard.
// Hand sequences cover reset, abort, held start and mid-run changes.
module tb_rectangle_filled_generator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a, b, c, d;
  logic [31:0] o0, o1, o2, o3;
  logic        valid;
  logic        done;

  rectangle_filled_generator #(.WIDTH(32)) dut (
    ._clock(clk),
    ._reset(rst),
    ._start(start),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    ._out0(o0),
    ._out1(o1),
    ._out2(o2),
    ._out3(o3),
    ._valid(valid),
    ._done(done)
  );

  typedef struct {
    logic [31:0] x, y, r, k;
  } pt_t;

  typedef struct {
    logic [31:0] a, b, c, d;
    int          npts;
  } vec_t;

  pt_t  q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vcount   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every valid point must match the head of the queue.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_point: got (%0h,%0h,%0h,%0h) expected none",
                 o0, o1, o2, o3);
      end else begin
        pt_t e;
        e = q.pop_front();
        check("pt_x", o0, e.x);
        check("pt_y", o1, e.y);
        check("pt_row", o2, e.r);
        check("pt_col", o3, e.k);
      end
    end
  end

  task automatic push_exp(input logic [31:0] pa, input logic [31:0] pb,
                          input int pc, input int pd);
    for (int r = 0; r < pc; r++) begin
      for (int k = 0; k < pd; k++) begin
        pt_t e;
        e.x = pa + 32'(k);
        e.y = pb + 32'(r);
        e.r = 32'(r);
        e.k = 32'(k);
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(done === 1'b1 && q.size() == 0) && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_idle_timeout", 32'(k >= 500), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int v0;
    v0 = vcount;
    a = v.a;
    b = v.b;
    c = v.c;
    d = v.d;
    if (v.npts > 0) push_exp(v.a, v.b, int'($signed(v.c)), int'($signed(v.d)));
    pulse_start();
    @(negedge clk);
    #1;
    check("done_after_start", 32'(done), 32'(v.npts == 0));
    check("valid_latency", 32'(valid), 32'd0);
    wait_idle();
    check("point_count", 32'(vcount - v0), 32'(v.npts));
  endtask

  initial begin
    int bad;
    int v0;
    int k;

    vecs[0] = '{32'd23, 32'd17, 32'd2, 32'd3, 6};
    vecs[1] = '{-32'sd2, -32'sd1, 32'd1, 32'd2, 2};
    vecs[2] = '{32'd23, 32'd17, 32'd5, 32'd0, 0};
    vecs[3] = '{32'd0, 32'd0, 32'd1, 32'd1, 1};
    vecs[4] = '{32'd5, 32'd5, -32'sd1, 32'd3, 0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd2, 32'd2, 4};
    vecs[6] = '{32'd10, 32'd20, 32'd3, 32'd1, 3};

    rst   = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out0", o0, 32'd0);
    check("rst_out1", o1, 32'd0);
    check("rst_out2", o2, 32'd0);
    check("rst_out3", o3, 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_done", 32'(done), 32'd1);

    a = 32'd23;
    b = 32'd17;
    c = 32'd5;
    d = 32'd0;
    pulse_start();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || done !== 1'b1) bad++;
      if ((o0 | o1 | o2 | o3) !== 32'd0) bad++;
    end
    check("empty_rect_quiet", 32'(bad), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    run_vec(vecs[0]);
    @(negedge clk);
`ifdef RECTANGLE_FILLED_ZERO_IDLE_EN
    check("idle_out0", o0, 32'd0);
    check("idle_out1", o1, 32'd0);
    check("idle_out2", o2, 32'd0);
    check("idle_out3", o3, 32'd0);
`else
    check("idle_out0", o0, 32'd25);
    check("idle_out1", o1, 32'd18);
    check("idle_out2", o2, 32'd1);
    check("idle_out3", o3, 32'd2);
`endif
    check("idle_valid", 32'(valid), 32'd0);

    a = 32'd3;
    b = 32'd4;
    c = 32'd4;
    d = 32'd4;
    push_exp(32'd3, 32'd4, 2, 4);
    v0 = vcount;
    pulse_start();
    k = 0;
    while (vcount - v0 < 5 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("abort_reach5", 32'(vcount - v0), 32'd5);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_out0", o0, 32'd0);
    check("abort_out3", o3, 32'd0);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_more", 32'(vcount - v0), 32'd5);
    vecs[0] = '{32'd3, 32'd4, 32'd1, 32'd2, 2};
    run_vec(vecs[0]);

    a = 32'd1;
    b = 32'd2;
    c = 32'd3;
    d = 32'd3;
    push_exp(32'd1, 32'd2, 3, 3);
    v0 = vcount;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    a = 32'd100;
    b = 32'd100;
    c = 32'd1;
    d = 32'd1;
    pulse_start();
    wait_idle();
    check("midrun_count", 32'(vcount - v0), 32'd9);

    a = 32'd7;
    b = 32'd8;
    c = 32'd1;
    d = 32'd2;
    push_exp(32'd7, 32'd8, 1, 2);
    push_exp(32'd7, 32'd8, 1, 2);
    v0 = vcount;
    start = 1'b1;
    k = 0;
    while (vcount - v0 < 4 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    check("held_start_count", 32'(vcount - v0), 32'd4);
    wait_idle();
    check("held_start_final", 32'(vcount - v0), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
